// File: rtl/t1_pkg.sv
// Shared constants and types for the program-memory loader path.
// The address/data widths here must match the core and the 256x8 program RAM.
package t1_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        CSUM,
        FINISH
    } state_e;

endpackage

// File: rtl/inactivity_timer.sv
// Counts idle cycles and flags expiry after TIMEOUT-1 of them.
// clear_i has priority over enable_i. The count saturates so that expired_o stays high until cleared.
module inactivity_timer #(
    parameter int TIMEOUT = 5000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            count_q <= '0;
        end else if (enable_i && (count_q != LAST)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expired_o = (count_q == LAST);

endmodule

// File: rtl/prog_loader.sv
// Receives framed bytes (sync, length, payload, checksum) and writes the payload into program memory.
// While a frame is being loaded, the block holds the core stopped.
module prog_loader #(
    parameter int                 ADDR_W    = t1_pkg::ADDR_W,
    parameter int                 DATA_W    = t1_pkg::DATA_W,
    parameter logic [DATA_W-1:0]  SYNC_BYTE = t1_pkg::SYNC_BYTE,
    parameter int                 TIMEOUT   = 5000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   load_count
);

    import t1_pkg::*;

    localparam int CNT_W = ADDR_W + 1;

    state_e            state_q;
    logic              in_ready_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_data_q;
    logic              cpu_hold_q;
    logic              load_done_q;
    logic              load_err_q;
    logic [CNT_W-1:0]  load_count_q;
    logic [CNT_W-1:0]  remaining_q;
    logic [DATA_W-1:0] sum_q;
    logic [DATA_W-1:0] sum_d;

    logic accept;
    logic frame_active;
    logic timer_expired;

    assign accept       = in_valid && in_ready_q;
    assign frame_active = (state_q == LEN) || (state_q == DATA) || (state_q == CSUM);
    assign sum_d        = sum_q + in_data;

    inactivity_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (accept || !frame_active),
        .enable_i  (frame_active),
        .expired_o (timer_expired)
    );

    // An accept on the expiry cycle wins over the timeout, since that cycle was not idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            in_ready_q   <= 1'b1;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            cpu_hold_q   <= 1'b0;
            load_done_q  <= 1'b0;
            load_err_q   <= 1'b0;
            load_count_q <= '0;
            remaining_q  <= '0;
            sum_q        <= '0;
        end else begin
            mem_we_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept && (in_data == SYNC_BYTE)) begin
                        state_q      <= LEN;
                        cpu_hold_q   <= 1'b1;
                        load_done_q  <= 1'b0;
                        load_err_q   <= 1'b0;
                        load_count_q <= '0;
                        sum_q        <= '0;
                    end
                end
                LEN: begin
                    if (accept) begin
                        remaining_q <= (in_data == '0) ? (CNT_W'(1) << ADDR_W) : CNT_W'(in_data);
                        state_q     <= DATA;
                    end else if (timer_expired) begin
                        load_err_q <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                DATA: begin
                    if (accept) begin
                        sum_q        <= sum_d;
                        remaining_q  <= remaining_q - 1'b1;
                        load_count_q <= load_count_q + 1'b1;
                        mem_we_q     <= 1'b1;
                        mem_addr_q   <= load_count_q[ADDR_W-1:0];
                        mem_data_q   <= in_data;
                        if (remaining_q == CNT_W'(1)) begin
                            state_q <= CSUM;
                        end
                    end else if (timer_expired) begin
                        load_err_q <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                CSUM: begin
                    if (accept) begin
                        if (in_data == sum_q) begin
                            load_done_q <= 1'b1;
                        end else begin
                            load_err_q <= 1'b1;
                        end
                        state_q    <= FINISH;
                        in_ready_q <= 1'b0;
                    end else if (timer_expired) begin
                        load_err_q <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                FINISH: begin
                    // A failed frame leaves memory untrustworthy, so the core stays held.
                    if (load_done_q) begin
                        cpu_hold_q <= 1'b0;
                    end
                    state_q    <= IDLE;
                    in_ready_q <= 1'b1;
                end
                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_data   = mem_data_q;
    assign cpu_hold   = cpu_hold_q;
    assign load_done  = load_done_q;
    assign load_err   = load_err_q;
    assign load_count = load_count_q;

endmodule
